// File: rtl/lc3_mem_ctrl_if.sv
// LC-3 memory/IO stage signal bundle: datapath controls, external memory port,
// keyboard and display lines. slave = controller side, master = environment side.
interface lc3_mem_ctrl_if;
    logic [15:0] main_bus;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        MIO_EN;
    logic        R_W;
    logic        R;
    logic [15:0] mdr_out;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic [7:0]  ddr_data;
    logic        ddr_valid;
    logic        ddr_ready;
    logic        bus_err;

    modport slave (
        input  main_bus, LD_MAR, LD_MDR, MIO_EN, R_W, mem_rdata, mem_ack,
               kb_valid, kb_data, ddr_ready,
        output R, mdr_out, mem_req, mem_we, mem_addr, mem_wdata,
               ddr_data, ddr_valid, bus_err
    );

    modport master (
        output main_bus, LD_MAR, LD_MDR, MIO_EN, R_W, mem_rdata, mem_ack,
               kb_valid, kb_data, ddr_ready,
        input  R, mdr_out, mem_req, mem_we, mem_addr, mem_wdata,
               ddr_data, ddr_valid, bus_err
    );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC-3 MAR/MDR, external memory handshake and memory-mapped KBSR/KBDR/DSR/DDR.
// Optional LC3_MEM_TIMEOUT_EN: abort a memory access after TIMEOUT_CYCLES without ack.
module lc3_mem_ctrl #(
    parameter logic [15:0] IO_BASE = 16'hFE00
`ifdef LC3_MEM_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input logic            clk,
    input logic            rst,
    lc3_mem_ctrl_if.slave  bus
);
    localparam int unsigned W  = 16;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    mar_q, mdr_q, rdata_q, rdata_d, io_rdata;
    logic            r_q, r_d, req_q, req_d, we_q, we_d;
    logic            kbdr_rd_q, kbdr_rd_d, ddr_wr;
    logic            kb_full_q, ddr_valid_q;
    logic [CW-1:0]   kbdr_q, ddr_data_q;
    logic            is_kbsr, is_kbdr, is_dsr, is_ddr, io_hit, busy;

    assign is_kbsr = (mar_q == IO_BASE);
    assign is_kbdr = (mar_q == IO_BASE + 16'd2);
    assign is_dsr  = (mar_q == IO_BASE + 16'd4);
    assign is_ddr  = (mar_q == IO_BASE + 16'd6);
    assign io_hit  = is_kbsr | is_kbdr | is_dsr | is_ddr;
    assign busy    = (state_q == S_BUSY);

    // IO register read mux; DDR and unused bits read as zero
    always_comb begin
        io_rdata = '0;
        if (is_kbsr)      io_rdata = {kb_full_q, 15'h0000};
        else if (is_kbdr) io_rdata = {8'h00, kbdr_q};
        else if (is_dsr)  io_rdata = {!ddr_valid_q, 15'h0000};
    end

`ifdef LC3_MEM_TIMEOUT_EN
    logic [W-1:0] tmo_q, tmo_d;
    logic         err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        r_d       = 1'b0;
        rdata_d   = rdata_q;
        kbdr_rd_d = 1'b0;
        ddr_wr    = 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.MIO_EN) begin
                    if (io_hit) begin
                        state_d   = S_DONE;
                        r_d       = 1'b1;
                        rdata_d   = io_rdata;
                        kbdr_rd_d = is_kbdr & !bus.R_W;
                        ddr_wr    = is_ddr & bus.R_W;
                    end else begin
                        state_d = S_BUSY;
                        req_d   = 1'b1;
                        we_d    = bus.R_W;
`ifdef LC3_MEM_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
            end
            S_BUSY: begin
                if (bus.mem_ack) begin
                    state_d = S_DONE;
                    r_d     = 1'b1;
                    rdata_d = bus.mem_rdata;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end
`ifdef LC3_MEM_TIMEOUT_EN
                else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_DONE;
                    r_d     = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            r_q       <= 1'b0;
            rdata_q   <= '0;
            kbdr_rd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            r_q       <= r_d;
            rdata_q   <= rdata_d;
            kbdr_rd_q <= kbdr_rd_d;
        end
    end

`ifdef LC3_MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign bus.bus_err = err_q;
`else
    assign bus.bus_err = 1'b0;
`endif

    // MAR/MDR frozen while a memory request is outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            mar_q <= '0;
            mdr_q <= '0;
        end else if (!busy) begin
            if (bus.LD_MAR) mar_q <= bus.main_bus;
            if (bus.LD_MDR) begin
                if (!bus.MIO_EN)             mdr_q <= bus.main_bus;
                else if (r_q && !bus.R_W)    mdr_q <= rdata_q;
            end
        end
    end

    // Keyboard: a new char in the same cycle as a KBDR read wins
    always_ff @(posedge clk) begin
        if (rst) begin
            kb_full_q <= 1'b0;
            kbdr_q    <= '0;
        end else if (bus.kb_valid && (!kb_full_q || kbdr_rd_q)) begin
            kbdr_q    <= bus.kb_data;
            kb_full_q <= 1'b1;
        end else if (kbdr_rd_q) begin
            kb_full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ddr_valid_q <= 1'b0;
            ddr_data_q  <= '0;
        end else if (ddr_wr) begin
            ddr_data_q  <= mdr_q[CW-1:0];
            ddr_valid_q <= 1'b1;
        end else if (bus.ddr_ready) begin
            ddr_valid_q <= 1'b0;
        end
    end

    assign bus.R         = r_q;
    assign bus.mdr_out   = mdr_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = mar_q;
    assign bus.mem_wdata = mdr_q;
    assign bus.ddr_data  = ddr_data_q;
    assign bus.ddr_valid = ddr_valid_q;
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed self-checking bench for lc3_mem_ctrl; timeout steps only with LC3_MEM_TIMEOUT_EN.
module tb_lc3_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    lc3_mem_ctrl_if bus();

    lc3_mem_ctrl #(
        .IO_BASE(16'hFE00)
`ifdef LC3_MEM_TIMEOUT_EN
        , .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_mar(input logic [15:0] v);
        bus.main_bus = v; bus.LD_MAR = 1'b1;
        cyc();
        bus.LD_MAR = 1'b0;
    endtask

    task automatic load_mdr(input logic [15:0] v);
        bus.main_bus = v; bus.LD_MDR = 1'b1; bus.MIO_EN = 1'b0;
        cyc();
        bus.LD_MDR = 1'b0;
    endtask

    // Drives one access; memory acks on request cycle ack_after+1, reads load MDR on R
    task automatic run_access(input logic rw, input int ack_after, input logic [15:0] rd,
                              output logic r_seen, output int req_cyc, output int lat,
                              output logic err_at_r, output logic [15:0] addr_ack,
                              output logic [15:0] wdata_ack, output logic we_ack);
        bus.MIO_EN = 1'b1; bus.R_W = rw;
        r_seen = 1'b0; req_cyc = 0; lat = 0; err_at_r = 1'b0;
        addr_ack = '0; wdata_ack = '0; we_ack = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            lat++;
            bus.mem_ack = 1'b0;
            if (bus.R) begin
                r_seen = 1'b1; err_at_r = bus.bus_err;
                break;
            end
            if (bus.mem_req) begin
                req_cyc++;
                if (req_cyc == ack_after + 1) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = rd;
                    addr_ack = bus.mem_addr; wdata_ack = bus.mem_wdata; we_ack = bus.mem_we;
                end
            end
        end
        bus.LD_MDR = r_seen & !rw;
        cyc();
        bus.LD_MDR = 1'b0; bus.MIO_EN = 1'b0; bus.mem_ack = 1'b0;
    endtask

    logic        r_seen, err_r, we_a;
    int          req_c, lat;
    logic [15:0] addr_a, wdata_a;

    task automatic io_rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        load_mar(addr);
        run_access(1'b0, 0, 16'h0, r_seen, req_c, lat, err_r, addr_a, wdata_a, we_a);
        chk(tag, {16'h0, bus.mdr_out}, {16'h0, exp});
    endtask

    task automatic io_wr(input logic [15:0] addr, input logic [15:0] d);
        load_mdr(d);
        load_mar(addr);
        run_access(1'b1, 0, 16'h0, r_seen, req_c, lat, err_r, addr_a, wdata_a, we_a);
    endtask

    initial begin
        bus.main_bus = '0; bus.LD_MAR = 0; bus.LD_MDR = 0; bus.MIO_EN = 0; bus.R_W = 0;
        bus.mem_rdata = '0; bus.mem_ack = 0; bus.kb_valid = 0; bus.kb_data = '0; bus.ddr_ready = 0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_R", 32'(bus.R), 0);
        chk("rst_req", 32'(bus.mem_req), 0);
        chk("rst_we", 32'(bus.mem_we), 0);
        chk("rst_mdr", 32'(bus.mdr_out), 0);
        chk("rst_mar", 32'(bus.mem_addr), 0);
        chk("rst_ddr_valid", 32'(bus.ddr_valid), 0);
        chk("rst_ddr_data", 32'(bus.ddr_data), 0);
        chk("rst_bus_err", 32'(bus.bus_err), 0);

        // memory read, ack three cycles after request
        load_mar(16'h3000);
        run_access(1'b0, 3, 16'h1234, r_seen, req_c, lat, err_r, addr_a, wdata_a, we_a);
        chk("rd_R", 32'(r_seen), 1);
        chk("rd_req_cycles", 32'(req_c), 4);
        chk("rd_latency", 32'(lat), 5);
        chk("rd_addr", 32'(addr_a), 32'h3000);
        chk("rd_we", 32'(we_a), 0);
        chk("rd_bus_err", 32'(err_r), 0);
        chk("rd_mdr", 32'(bus.mdr_out), 32'h1234);
        chk("rd_R_pulse", 32'(bus.R), 0);

        // memory write
        load_mdr(16'hABCD);
        load_mar(16'h4000);
        run_access(1'b1, 1, 16'h0000, r_seen, req_c, lat, err_r, addr_a, wdata_a, we_a);
        chk("wr_R", 32'(r_seen), 1);
        chk("wr_latency", 32'(lat), 3);
        chk("wr_we", 32'(we_a), 1);
        chk("wr_addr", 32'(addr_a), 32'h4000);
        chk("wr_wdata", 32'(wdata_a), 32'hABCD);
        chk("wr_mdr_kept", 32'(bus.mdr_out), 32'hABCD);
        chk("wr_req_off", 32'(bus.mem_req), 0);

        // FE08 is not an IO register: minimum-latency memory read
        load_mar(16'hFE08);
        run_access(1'b0, 0, 16'h5A5A, r_seen, req_c, lat, err_r, addr_a, wdata_a, we_a);
        chk("fe08_req_cycles", 32'(req_c), 1);
        chk("fe08_latency", 32'(lat), 2);
        chk("fe08_mdr", 32'(bus.mdr_out), 32'h5A5A);

        // keyboard: capture, drop when full, clear on KBDR read
        bus.kb_valid = 1'b1; bus.kb_data = 8'h41; cyc();
        bus.kb_data = 8'h42; cyc();
        bus.kb_valid = 1'b0;
        io_rd("kbsr_full", 16'hFE00, 16'h8000);
        chk("io_latency", 32'(lat), 1);
        chk("io_no_req", 32'(req_c), 0);
        io_rd("kbdr_first", 16'hFE02, 16'h0041);
        io_rd("kbsr_empty", 16'hFE00, 16'h0000);

        // new char in the same cycle as the KBDR read completes
        bus.kb_valid = 1'b1; bus.kb_data = 8'h43; cyc();
        bus.kb_valid = 1'b0;
        load_mar(16'hFE02);
        bus.MIO_EN = 1'b1; bus.R_W = 1'b0;
        cyc();
        chk("kb_race_R", 32'(bus.R), 1);
        bus.kb_valid = 1'b1; bus.kb_data = 8'h44; bus.LD_MDR = 1'b1;
        cyc();
        bus.kb_valid = 1'b0; bus.LD_MDR = 1'b0; bus.MIO_EN = 1'b0;
        chk("kb_race_mdr", 32'(bus.mdr_out), 32'h0043);
        io_rd("kb_race_kbsr", 16'hFE00, 16'h8000);
        io_rd("kb_race_kbdr", 16'hFE02, 16'h0044);

        // display
        io_rd("dsr_idle", 16'hFE04, 16'h8000);
        io_wr(16'hFE06, 16'h0048);
        chk("ddr_latency", 32'(lat), 1);
        chk("ddr_valid", 32'(bus.ddr_valid), 1);
        chk("ddr_data", 32'(bus.ddr_data), 32'h48);
        io_rd("dsr_busy", 16'hFE04, 16'h0000);
        io_wr(16'hFE06, 16'h1249);
        chk("ddr_overwrite", 32'(bus.ddr_data), 32'h49);
        bus.ddr_ready = 1'b1; cyc();
        bus.ddr_ready = 1'b0;
        chk("ddr_drained", 32'(bus.ddr_valid), 0);
        io_rd("dsr_ready", 16'hFE04, 16'h8000);
        io_rd("ddr_read_zero", 16'hFE06, 16'h0000);
        io_wr(16'hFE02, 16'hFFFF);
        io_wr(16'hFE00, 16'hFFFF);
        io_rd("kbsr_wr_ignored", 16'hFE00, 16'h0000);
        io_rd("kbdr_wr_ignored", 16'hFE02, 16'h0044);

        // reset in the middle of a memory request
        load_mar(16'h5000);
        bus.MIO_EN = 1'b1; bus.R_W = 1'b0;
        cyc();
        chk("mid_req_up", 32'(bus.mem_req), 1);
        rst = 1'b1;
        cyc();
        chk("mid_req_drop", 32'(bus.mem_req), 0);
        rst = 1'b0; bus.MIO_EN = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBEEF;
        cyc();
        bus.mem_ack = 1'b0;
        chk("mid_no_R", 32'(bus.R), 0);
        cyc();
        chk("mid_no_R_late", 32'(bus.R), 0);
        chk("mid_mdr", 32'(bus.mdr_out), 0);

`ifdef LC3_MEM_TIMEOUT_EN
        // no ack: abort after four BUSY cycles
        load_mdr(16'h1111);
        load_mar(16'h6000);
        run_access(1'b0, 100, 16'hFFFF, r_seen, req_c, lat, err_r, addr_a, wdata_a, we_a);
        chk("tmo_R", 32'(r_seen), 1);
        chk("tmo_bus_err", 32'(err_r), 1);
        chk("tmo_req_cycles", 32'(req_c), 4);
        chk("tmo_mdr", 32'(bus.mdr_out), 0);
        chk("tmo_err_pulse", 32'(bus.bus_err), 0);
`else
        chk("no_tmo_bus_err", 32'(bus.bus_err), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
